// File: rtl/alu_gate_pkg.sv
// Shared constants for the ALU bitwise-gate checker: opcode and FSM state encodings.
// Pure declarations; no timing or storage of its own.
// No flow control; imported by the checker and the reference model.
package alu_gate_pkg;

    // Gate opcodes as driven on the op bus of the stimulus interface
    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    // Checker run-control FSM encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/gate_ref_model.sv
// Expected result of a bitwise gate for (op, x, y); shared with the ALU scoreboard.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its own valid.
module gate_ref_model
    import alu_gate_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] exp_o
);

    // Select the gate function named by the opcode
    always_comb begin
        exp_o = '0;
        case (op_i)
            OP_NAND: exp_o = ~(x_i & y_i);
            OP_AND:  exp_o = x_i & y_i;
            OP_OR:   exp_o = x_i | y_i;
            OP_XOR:  exp_o = x_i ^ y_i;
            default: exp_o = '0;
        endcase
    end

endmodule

// File: rtl/gate_result_checker.sv
// Checks (op, x, y, o) samples from a gate under test; counts pass/fail, latches first mismatch.
// Latency: accept at edge N, counters/snapshot updated at edge N+1.
// Backpressure: in_ready is high only in RUN; samples offered in any other state are not taken.
module gate_result_checker
    import alu_gate_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] o,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err,
    output logic [CNT_W-1:0] err_idx,
    output logic [WIDTH-1:0] err_x,
    output logic [WIDTH-1:0] err_y,
    output logic [WIDTH-1:0] err_o,
    output logic [WIDTH-1:0] err_exp
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Run control
    logic [1:0] state_q, state_d;
    logic       accept;
    logic       run_start;

    // Stage 1: captured sample plus its accept index
    logic             s1_vld_q;
    logic [1:0]       s1_op_q;
    logic [WIDTH-1:0] s1_x_q, s1_y_q, s1_o_q;
    logic [CNT_W-1:0] s1_idx_q;
    logic [CNT_W-1:0] acc_idx_q, acc_idx_d;

    // Stage 2: counters and first-mismatch snapshot
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_idx_q, err_idx_d;
    logic [WIDTH-1:0] err_x_q, err_x_d;
    logic [WIDTH-1:0] err_y_q, err_y_d;
    logic [WIDTH-1:0] err_o_q, err_o_d;
    logic [WIDTH-1:0] err_exp_q, err_exp_d;

    logic [WIDTH-1:0] s1_exp;
    logic             s1_miss;

    assign in_ready  = (state_q == ST_RUN);
    assign accept    = in_valid & in_ready;
    // start is only honoured when no run is in flight
    assign run_start = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

    // Next-state logic for the run FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (accept && in_last) state_d = ST_DRAIN;
            // The last sample sits in stage 1 during DRAIN and is counted on
            // the same edge that enters DONE, so done and final counts align.
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  if (start) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Accept index: numbers accepted samples, saturating, cleared per run
    always_comb begin
        acc_idx_d = acc_idx_q;
        if (run_start)
            acc_idx_d = '0;
        else if (accept && (acc_idx_q != CNT_MAX))
            acc_idx_d = acc_idx_q + 1'b1;
    end

    // Stage 1 capture of the accepted sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_op_q   <= '0;
            s1_x_q    <= '0;
            s1_y_q    <= '0;
            s1_o_q    <= '0;
            s1_idx_q  <= '0;
            acc_idx_q <= '0;
        end else begin
            s1_vld_q  <= accept & ~run_start;
            acc_idx_q <= acc_idx_d;
            if (accept) begin
                s1_op_q  <= op;
                s1_x_q   <= x;
                s1_y_q   <= y;
                s1_o_q   <= o;
                s1_idx_q <= acc_idx_q;
            end
        end
    end

    gate_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .op_i  (s1_op_q),
        .x_i   (s1_x_q),
        .y_i   (s1_y_q),
        .exp_o (s1_exp)
    );

    // Case inequality so an X/Z bit on o in simulation counts as a mismatch
    assign s1_miss = (s1_o_q !== s1_exp);

    // Stage 2: compare result, bump a saturating counter, capture first mismatch
    always_comb begin
        pass_d    = pass_q;
        fail_d    = fail_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;
        err_x_d   = err_x_q;
        err_y_d   = err_y_q;
        err_o_d   = err_o_q;
        err_exp_d = err_exp_q;
        if (run_start) begin
            pass_d    = '0;
            fail_d    = '0;
            err_d     = 1'b0;
            err_idx_d = '0;
            err_x_d   = '0;
            err_y_d   = '0;
            err_o_d   = '0;
            err_exp_d = '0;
        end else if (s1_vld_q) begin
            if (s1_miss) begin
                if (fail_q == '0) begin
                    err_d     = 1'b1;
                    err_idx_d = s1_idx_q;
                    err_x_d   = s1_x_q;
                    err_y_d   = s1_y_q;
                    err_o_d   = s1_o_q;
                    err_exp_d = s1_exp;
                end
                if (fail_q != CNT_MAX) fail_d = fail_q + 1'b1;
            end else if (pass_q != CNT_MAX) begin
                pass_d = pass_q + 1'b1;
            end
        end
    end

    // Stage 2 result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_q    <= '0;
            fail_q    <= '0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
            err_x_q   <= '0;
            err_y_q   <= '0;
            err_o_q   <= '0;
            err_exp_q <= '0;
        end else begin
            pass_q    <= pass_d;
            fail_q    <= fail_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
            err_x_q   <= err_x_d;
            err_y_q   <= err_y_d;
            err_o_q   <= err_o_d;
            err_exp_q <= err_exp_d;
        end
    end

    assign busy     = (state_q == ST_RUN) | (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign err      = err_q;
    assign err_idx  = err_idx_q;
    assign err_x    = err_x_q;
    assign err_y    = err_y_q;
    assign err_o    = err_o_q;
    assign err_exp  = err_exp_q;

endmodule

// File: tb/tb_gate_result_checker.sv
// Bench for gate_result_checker: directed scenarios plus random runs against a sample-level model.
// Two instances share stimulus: CNT_W=8 and CNT_W=3 (saturation).
// Inputs change 1ns after the rising edge; outputs are read at the same point.
module tb_gate_result_checker;

    localparam int W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, in_valid, in_last;
    logic [1:0]   op;
    logic [W-1:0] x, y, o;

    logic         a_in_ready, a_busy, a_done, a_err;
    logic [7:0]   a_pass, a_fail, a_err_idx;
    logic [W-1:0] a_err_x, a_err_y, a_err_o, a_err_exp;

    logic         b_in_ready, b_busy, b_done, b_err;
    logic [2:0]   b_pass, b_fail, b_err_idx;
    logic [W-1:0] b_err_x, b_err_y, b_err_o, b_err_exp;

    gate_result_checker #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_last(in_last), .op(op), .x(x), .y(y), .o(o), .busy(a_busy), .done(a_done),
        .pass_cnt(a_pass), .fail_cnt(a_fail), .err(a_err), .err_idx(a_err_idx),
        .err_x(a_err_x), .err_y(a_err_y), .err_o(a_err_o), .err_exp(a_err_exp)
    );

    gate_result_checker #(.WIDTH(W), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_last(in_last), .op(op), .x(x), .y(y), .o(o), .busy(b_busy), .done(b_done),
        .pass_cnt(b_pass), .fail_cnt(b_fail), .err(b_err), .err_idx(b_err_idx),
        .err_x(b_err_x), .err_y(b_err_y), .err_o(b_err_o), .err_exp(b_err_exp)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, unsaturated; saturation applied when comparing
    int           m_n, m_pass, m_fail, m_err_idx;
    bit           m_err;
    logic [W-1:0] m_ex, m_ey, m_eo, m_eexp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] gate_fn(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            2'b00:   return ~(a & b);
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_clear();
        m_n = 0; m_pass = 0; m_fail = 0; m_err_idx = 0; m_err = 1'b0;
        m_ex = '0; m_ey = '0; m_eo = '0; m_eexp = '0;
    endtask

    task automatic model_accept(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
        logic [W-1:0] e;
        e = gate_fn(f, a, b);
        if (r !== e) begin
            if (m_fail == 0) begin
                m_err = 1'b1; m_err_idx = m_n;
                m_ex = a; m_ey = b; m_eo = r; m_eexp = e;
            end
            m_fail++;
        end else begin
            m_pass++;
        end
        m_n++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [1:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic last);
        check("in_ready", 32'(a_in_ready), 32'd1);
        in_valid = 1'b1; op = f; x = a; y = b; o = r; in_last = last;
        step();
        model_accept(f, a, b, r);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic check_results(input string tag);
        check({tag, ".pass"},   32'(a_pass),    32'(sat(m_pass, 8)));
        check({tag, ".fail"},   32'(a_fail),    32'(sat(m_fail, 8)));
        check({tag, ".err"},    32'(a_err),     32'(m_err));
        check({tag, ".idx"},    32'(a_err_idx), 32'(sat(m_err_idx, 8)));
        check({tag, ".ex"},     32'(a_err_x),   32'(m_ex));
        check({tag, ".ey"},     32'(a_err_y),   32'(m_ey));
        check({tag, ".eo"},     32'(a_err_o),   32'(m_eo));
        check({tag, ".eexp"},   32'(a_err_exp), 32'(m_eexp));
        check({tag, ".s.pass"}, 32'(b_pass),    32'(sat(m_pass, 3)));
        check({tag, ".s.fail"}, 32'(b_fail),    32'(sat(m_fail, 3)));
        check({tag, ".s.err"},  32'(b_err),     32'(m_err));
        check({tag, ".s.idx"},  32'(b_err_idx), 32'(sat(m_err_idx, 3)));
        check({tag, ".s.eo"},   32'(b_err_o),   32'(m_eo));
    endtask

    // After the final accept: counts one edge later, then done/idle handshake
    task automatic finish_run(input string tag);
        step();
        check_results(tag);
        step();
        check({tag, ".done"},   32'(a_done),     32'd1);
        check({tag, ".s.done"}, 32'(b_done),     32'd1);
        check({tag, ".busy"},   32'(a_busy),     32'd0);
        check({tag, ".rdy"},    32'(a_in_ready), 32'd0);
    endtask

    task automatic check_idle_cleared(input string tag);
        check({tag, ".busy"}, 32'(a_busy),     32'd0);
        check({tag, ".done"}, 32'(a_done),     32'd0);
        check({tag, ".rdy"},  32'(a_in_ready), 32'd0);
        check_results(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   f;
        logic [W-1:0] a, b, r;
        int           len, gap;

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        op = '0; x = '0; y = '0; o = '0;
        model_clear();

        // Reset values
        repeat (4) step();
        check_idle_cleared("reset");
        check("reset.s.busy", 32'(b_busy), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_reset.busy", 32'(a_busy), 32'd0);

        // Correct NAND sweep
        pulse_start();
        check("nand.busy", 32'(a_busy), 32'd1);
        check("nand.done", 32'(a_done), 32'd0);
        send(2'b00, 4'b1111, 4'b0000, 4'b1111, 1'b0);
        check("nand.lat0", 32'(a_pass), 32'd0);
        send(2'b00, 4'b0000, 4'b1111, 4'b1111, 1'b0);
        check("nand.lat1", 32'(a_pass), 32'd1);
        send(2'b00, 4'b1111, 4'b1111, 4'b0000, 1'b0);
        send(2'b00, 4'b1111, 4'b0110, 4'b1001, 1'b1);
        check("nand.drain_busy", 32'(a_busy), 32'd1);
        finish_run("nand");
        check("nand.pass4", 32'(a_pass), 32'd4);

        // Injected fault, started from DONE
        pulse_start();
        check("fault.cleared", 32'(a_pass), 32'd0);
        send(2'b00, 4'b1111, 4'b0110, 4'b1001, 1'b0);
        send(2'b00, 4'b1111, 4'b1111, 4'b0001, 1'b0);
        send(2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b1);
        finish_run("fault");
        check("fault.fail2",  32'(a_fail),    32'd2);
        check("fault.idx1",   32'(a_err_idx), 32'd1);
        check("fault.eo",     32'(a_err_o),   32'b0001);
        check("fault.eexp",   32'(a_err_exp), 32'b0000);

        // Mixed ops with idle gaps; counters must hold steady on idle cycles
        pulse_start();
        send(2'b01, 4'b1100, 4'b1010, 4'b1000, 1'b0);
        repeat (2) begin
            step();
            check("mixed.gap", 32'(a_pass), 32'(m_pass));
        end
        send(2'b10, 4'b1100, 4'b1010, 4'b1110, 1'b0);
        repeat (2) begin
            step();
            check("mixed.gap", 32'(a_pass), 32'(m_pass));
        end
        send(2'b11, 4'b1100, 4'b1010, 4'b0110, 1'b1);
        finish_run("mixed");
        check("mixed.pass3", 32'(a_pass), 32'd3);

        // Saturation on the CNT_W=3 instance, then restart from DONE
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            f = 2'($urandom_range(0, 3)); a = 4'($urandom); b = 4'($urandom);
            send(f, a, b, gate_fn(f, a, b), i == 9);
        end
        finish_run("sat");
        check("sat.s.pass7", 32'(b_pass), 32'd7);
        check("sat.pass10",  32'(a_pass), 32'd10);
        pulse_start();
        check("restart.pass",   32'(a_pass), 32'd0);
        check("restart.s.pass", 32'(b_pass), 32'd0);
        check("restart.done",   32'(a_done), 32'd0);
        check("restart.busy",   32'(a_busy), 32'd1);

        // Reset mid-run discards partial results
        send(2'b01, 4'b1111, 4'b0101, 4'b0101, 1'b0);
        send(2'b01, 4'b1111, 4'b0101, 4'b1111, 1'b0);
        send(2'b10, 4'b0001, 4'b0010, 4'b0011, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst.async_busy", 32'(a_busy), 32'd0);
        step();
        rst_n = 1'b1;
        model_clear();
        check_idle_cleared("midrst");

        // start pulsed during RUN is ignored
        pulse_start();
        send(2'b11, 4'b1010, 4'b0110, 4'b1100, 1'b0);
        send(2'b00, 4'b1010, 4'b0110, 4'b0001, 1'b0);
        start = 1'b1;
        send(2'b10, 4'b1010, 4'b0110, 4'b1110, 1'b0);
        start = 1'b0;
        check("runstart.busy", 32'(a_busy), 32'd1);
        send(2'b01, 4'b1010, 4'b0110, 4'b0010, 1'b0);
        send(2'b00, 4'b0000, 4'b0000, 4'b1111, 1'b1);
        finish_run("runstart");

        // Random runs with occasional faults and idle gaps
        for (int run = 0; run < 40; run++) begin
            pulse_start();
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                f = 2'($urandom_range(0, 3)); a = 4'($urandom); b = 4'($urandom);
                r = gate_fn(f, a, b);
                if ($urandom_range(0, 3) == 0) r = r ^ 4'($urandom_range(1, 15));
                send(f, a, b, r, i == len - 1);
                if (i != len - 1) begin
                    gap = $urandom_range(0, 2);
                    repeat (gap) step();
                end
            end
            finish_run("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
